// File: rtl/character_jump_ctrl_pkg.sv
// Shared types and constants for the character jump controller and its draw stage.
package character_jump_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_AIR  = 2'b01,
    S_LAND = 2'b10
  } state_e;

  localparam int GAME_WIDTH_PX  = 800;
  localparam int GAME_HEIGHT_PX = 600;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

endpackage

// File: rtl/character_jump_ctrl_draw_rect.sv
// One-stage VGA bus stage that overlays a solid rectangle at (x_i, y_i) when en_i is high.
module character_jump_ctrl_draw_rect
  import character_jump_ctrl_pkg::*;
#(
  parameter logic [11:0] COLOR  = 12'hFF0,
  parameter int          WIDTH  = 40,
  parameter int          HEIGHT = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [9:0]              x_i,
  input  logic [9:0]              y_i,
  input  logic [VGA_BUS_SIZE-1:0] bus_i,
  output logic [VGA_BUS_SIZE-1:0] bus_o
);

  localparam logic [11:0] W = 12'(WIDTH);
  localparam logic [11:0] H = 12'(HEIGHT);

  vga_bus_t bus_in;
  vga_bus_t bus_d;
  vga_bus_t bus_q;
  logic     in_rect;

  assign bus_in = vga_bus_t'(bus_i);

  always_comb begin
    in_rect = ({1'b0, bus_in.hcount} >= {2'b00, x_i}) &&
              ({1'b0, bus_in.hcount} <  ({2'b00, x_i} + W)) &&
              ({1'b0, bus_in.vcount} >= {2'b00, y_i}) &&
              ({1'b0, bus_in.vcount} <  ({2'b00, y_i} + H));
    bus_d = bus_in;
    if (en_i && in_rect) bus_d.rgb = COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) bus_q <= '0;
    else     bus_q <= bus_d;
  end

  assign bus_o = bus_q;

endmodule

// File: rtl/character_jump_ctrl.sv
// Ballistic left/right jump controller with clamped x and a rectangle draw stage.
// Optional macro JUMP_QUEUE_EN holds one pending request captured while airborne/landing.
module character_jump_ctrl
  import character_jump_ctrl_pkg::*;
#(
  parameter logic [11:0] CHAR_COLOR  = 12'hFF0,
  parameter int          CHAR_WIDTH  = 40,
  parameter int          CHAR_HEIGHT = 60,
  parameter int          GAME_WIDTH  = GAME_WIDTH_PX,
  parameter int          BASE_Y      = 450,
  parameter int          JUMP_V0     = 8,
  parameter int          GRAVITY     = 1,
  parameter int          JUMP_DX     = 5,
  parameter int          TICK_DIV    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    module_en,
  input  logic                    jump_left,
  input  logic                    jump_right,
  input  logic                    one_ms_tick,
  output logic                    landed,
  output logic                    airborne,
  output logic [9:0]              char_x,
  output logic [9:0]              char_y,
  input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out
);

  localparam logic [9:0] X_MAX   = 10'(GAME_WIDTH - CHAR_WIDTH);
  localparam logic [9:0] X_RST   = 10'(GAME_WIDTH / 2 - CHAR_WIDTH / 2 - 1);
  localparam logic [9:0] Y_BASE  = 10'(BASE_Y);
  localparam logic [9:0] DX      = 10'(JUMP_DX);
  localparam logic [5:0] V0      = 6'(JUMP_V0);
  localparam logic [5:0] GRAV    = 6'(GRAVITY);
  localparam logic [5:0] VY_END  = 6'(-JUMP_V0);
  localparam logic [7:0] TDIV_M1 = 8'(TICK_DIV - 1);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [5:0] vy_q, vy_d;
  logic [7:0] tick_q, tick_d;
  logic       left_q, left_d;
  logic       single_req;
  logic [10:0] x_sum;
  logic [9:0] x_right, x_left;
`ifdef JUMP_QUEUE_EN
  logic       pend_valid_q, pend_valid_d;
  logic       pend_left_q, pend_left_d;
`endif

  assign single_req = jump_left ^ jump_right;
  assign x_sum      = {1'b0, x_q} + {1'b0, DX};
  assign x_right    = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
  assign x_left     = (x_q < DX) ? '0 : (x_q - DX);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    tick_d  = tick_q;
    left_d  = left_q;
`ifdef JUMP_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_left_d  = pend_left_q;
    if ((state_q == S_AIR || state_q == S_LAND) && single_req && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_left_d  = jump_left;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (!module_en) begin
          x_d = X_RST;
`ifdef JUMP_QUEUE_EN
        end else if (pend_valid_q) begin
          left_d       = pend_left_q;
          vy_d         = V0;
          tick_d       = '0;
          state_d      = S_AIR;
          pend_valid_d = 1'b0;
`endif
        end else if (single_req) begin
          left_d  = jump_left;
          vy_d    = V0;
          tick_d  = '0;
          state_d = S_AIR;
        end
      end
      S_AIR: begin
        if (one_ms_tick) begin
          if (tick_q == TDIV_M1) begin
            tick_d = '0;
            // vy is two's complement with positive = up, so subtracting it moves y upward
            y_d    = y_q - {{4{vy_q[5]}}, vy_q};
            x_d    = left_q ? x_left : x_right;
            if (vy_q == VY_END) begin
              y_d     = Y_BASE;
              vy_d    = '0;
              state_d = S_LAND;
            end else begin
              vy_d = vy_q - GRAV;
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      S_LAND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= X_RST;
      y_q     <= Y_BASE;
      vy_q    <= '0;
      tick_q  <= '0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      tick_q  <= tick_d;
      left_q  <= left_d;
    end
  end

`ifdef JUMP_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_left_q  <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_left_q  <= pend_left_d;
    end
  end
`endif

  assign landed   = (state_q == S_LAND);
  assign airborne = (state_q == S_AIR);
  assign char_x   = x_q;
  assign char_y   = y_q;

  character_jump_ctrl_draw_rect #(
    .COLOR  (CHAR_COLOR),
    .WIDTH  (CHAR_WIDTH),
    .HEIGHT (CHAR_HEIGHT)
  ) u_draw (
    .clk   (clk),
    .rst   (rst),
    .en_i  (module_en),
    .x_i   (x_q),
    .y_i   (y_q),
    .bus_i (vga_bus_in),
    .bus_o (vga_bus_out)
  );

endmodule
